id_ex_skid_reg: RTL

ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

---
 rtl/id_ex_skid_reg.sv | 127 ++++++++++++
 1 files changed

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with a one-entry skid buffer.
// in_ready comes only from registered state, so it never depends on out_ready.
// out_ctrl is zeroed for bubbles. bubble_cnt is a saturating count of bubbles delivered to EX.
module id_ex_skid_reg #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_rd1,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_W-1:0]  out_rs,
  output logic [REG_W-1:0]  out_rt,
  output logic [REG_W-1:0]  out_rd,
  input  logic              flush,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned PayW = CTRL_W + 4 * DATA_W + 3 * REG_W;

  logic [PayW-1:0]   in_pay;
  logic [PayW-1:0]   main_q, main_d;
  logic [PayW-1:0]   skid_q, skid_d;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CTRL_W-1:0] main_ctrl;
  logic              in_xfer;
  logic              out_xfer;

  assign in_pay = {in_ctrl, in_pc, in_rd1, in_rd2, in_imm, in_rs, in_rt, in_rd};

  assign in_ready = ~skid_valid_q & ~Reset;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_valid_q & out_ready;

  // Next-state for the valid bits and payload registers.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      // The out-transfer of this cycle has already been sampled by EX. Drop everything else.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      unique case ({main_valid_q, skid_valid_q})
        2'b00: begin
          if (in_xfer) begin
            main_d       = in_pay;
            main_valid_d = 1'b1;
          end
        end
        2'b10: begin
          if (in_xfer && out_xfer) begin
            main_d = in_pay;
          end else if (in_xfer) begin
            skid_d       = in_pay;
            skid_valid_d = 1'b1;
          end else if (out_xfer) begin
            main_valid_d = 1'b0;
          end
        end
        2'b11: begin
          if (out_xfer) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          // Skid valid without main is unreachable. Recover to empty.
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Saturating bubble counter: a bubble is a cycle where EX is ready but nothing is valid.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (out_ready && !main_valid_q && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers with a synchronous reset that takes priority over flush and transfers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign {main_ctrl, out_pc, out_rd1, out_rd2, out_imm, out_rs, out_rt, out_rd} = main_q;
  assign out_valid  = main_valid_q;
  assign out_ctrl   = main_valid_q ? main_ctrl : '0;
  assign bubble_cnt = bubble_cnt_q;

endmodule
